stack_param: RTL
================

// Module: stack_param
// PURPOSE
//  Parametrised LIFO stack: WIDTH-bit entries, DEPTH entries, one clock, synchronous active-low reset.
//  Adds over the fixed 5x10 stack: correct Full/Empty polarity, simultaneous push+pop (replace-top), registered
//  pop data with valid strobe, combinational top-of-stack peek, occupancy count, sticky overflow/underflow errors.
//  Used as an operand/return stack between a controller FSM and datapath; producer and consumer in same clock domain.
// PARAMETERS
//  WIDTH  5   entry width in bits (>=1)
//  DEPTH  10  number of entries (>=2; need not be a power of two)
//  CW     $clog2(DEPTH+1)  localparam: Count width
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  RstN       in   1      synchronous active-low reset, sampled on rising edge of clk
//  Data_In    in   WIDTH  push data
//  Push       in   1      push request, one entry per cycle while high
//  Pop        in   1      pop request, one entry per cycle while high
//  Err_Clr    in   1      clears Overflow/Underflow
//  Data_Out   out  WIDTH  registered popped entry, valid when Out_Valid=1
//  Out_Valid  out  1      1-cycle strobe: Data_Out updated by an accepted pop
//  Top        out  WIDTH  combinational peek of mem[Count-1]; 0 when Empty
//  Count      out  CW     current occupancy, 0..DEPTH
//  Full       out  1      Count==DEPTH
//  Empty      out  1      Count==0
//  Overflow   out  1      sticky: push attempted while Full (and no accepted pop)
//  Underflow  out  1      sticky: pop attempted while Empty
//  Max_Count  out  CW     high-water mark (only with STACK_HWM_EN)
// BEHAVIOUR
//  Reset (RstN=0 at edge): Count=0, Data_Out=0, Out_Valid=0, Overflow=0, Underflow=0, Max_Count=0;
//   Empty=1, Full=0 (both decoded from Count). Memory contents not reset. Reset overrides all requests, incl. mid-burst.
//  Full/Empty/Count are registered-state decodes; they reflect the cycle's operation from the next cycle.
//  Per-cycle decision on (Push,Pop), evaluated against Count before the edge:
//   00: no change; Out_Valid=0.
//   10: if !Full: mem[Count]<=Data_In, Count+1. If Full: dropped, Overflow<=1.
//   01: if !Empty: Data_Out<=mem[Count-1], Out_Valid<=1, Count-1. If Empty: Underflow<=1, Data_Out holds, Out_Valid=0.
//   11, !Empty (incl. Full): replace-top: Data_Out<=mem[Count-1], Out_Valid<=1, mem[Count-1]<=Data_In, Count unchanged,
//       no Overflow even when Full.
//   11, Empty: push performed (mem[0]<=Data_In, Count=1), Underflow<=1, Out_Valid=0; no bypass of Data_In.
//  Pop latency: 1 cycle (request at edge N -> Data_Out/Out_Valid valid after edge N).
//  Out_Valid is high for exactly one cycle per accepted pop; back-to-back pops give consecutive strobes.
//  Top = mem[Count-1] combinationally when !Empty, else 0; reflects pushes from the next cycle.
//  Index arithmetic in CW bits; Count never exceeds DEPTH nor wraps below 0.
//  Err_Clr: clears both sticky flags at the edge; a new error in the same cycle wins (flag set).
// CONFIGURATION
//  STACK_HWM_EN defined: Max_Count tracks max Count reached since reset (updated with next-Count, same edge),
//   cleared only by reset.
//  STACK_HWM_EN undefined: Max_Count port present, tied to 0; no tracking logic.
// TESTING
//  Reset then push 1..10 (WIDTH=5, DEPTH=10) -> Count 1..10, Full=1 after 10th, Empty=0, Top=10.
//  From full, push 31 -> dropped, Count=10, Overflow=1; Err_Clr -> Overflow=0 next cycle.
//  From full, 10 pops -> Data_Out 10,9..1 each with Out_Valid pulse, Empty=1, then pop -> Underflow=1, Out_Valid=0.
//  Push 7, 8 then Push+Pop with Data_In=3 -> Data_Out=8, Out_Valid=1, Count=2, Top=3.
//  Empty, Push+Pop with 5 -> Count=1, Top=5, Underflow=1, Out_Valid=0.
//  Push 4 entries, RstN=0 for one edge mid-burst -> Count=0, Empty=1, flags 0; HWM_EN: Max_Count=4 before, 0 after.

Source files
------------

// File: rtl/stack_param_if.sv
// Bus interface for stack_param: push/pop requests, error clear, and all
// status/data outputs. The master side drives requests; the slave (the
// stack itself) drives data and status.
interface stack_param_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 10
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] Data_In;
  logic             Push;
  logic             Pop;
  logic             Err_Clr;
  logic [WIDTH-1:0] Data_Out;
  logic             Out_Valid;
  logic [WIDTH-1:0] Top;
  logic [CW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             Overflow;
  logic             Underflow;
  logic [CW-1:0]    Max_Count;

  modport master (
    output Data_In, Push, Pop, Err_Clr,
    input  Data_Out, Out_Valid, Top, Count, Full, Empty, Overflow, Underflow, Max_Count
  );

  modport slave (
    input  Data_In, Push, Pop, Err_Clr,
    output Data_Out, Out_Valid, Top, Count, Full, Empty, Overflow, Underflow, Max_Count
  );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO stack (WIDTH-bit entries, DEPTH entries).
// Simultaneous push+pop replaces the top entry; pop data is registered with a
// one-cycle valid strobe; Top is a combinational peek; Overflow/Underflow are
// sticky until Err_Clr or reset.
// Optional feature: define STACK_HWM_EN to track the occupancy high-water
// mark on Max_Count; otherwise Max_Count is tied to zero.
module stack_param #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 10
) (
  input  logic            clk,
  input  logic            RstN,
  stack_param_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    top_idx_s;
  logic [WIDTH-1:0] top_data_s;

  // Index of the current top entry; only meaningful while not empty.
  assign top_idx_s  = AW'(count_q - CNT_ONE);
  assign top_data_s = mem_q[top_idx_s];

  // Next-state decision for one (Push, Pop) pair against the pre-edge occupancy.
  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    wr_en_s     = 1'b0;
    wr_idx_s    = AW'(count_q);
    overflow_d  = bus.Err_Clr ? 1'b0 : overflow_q;
    underflow_d = bus.Err_Clr ? 1'b0 : underflow_q;
    case ({bus.Push, bus.Pop})
      2'b10: begin
        if (!full_q) begin
          wr_en_s  = 1'b1;
          wr_idx_s = AW'(count_q);
          count_d  = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_q) begin
          data_out_d  = top_data_s;
          out_valid_d = 1'b1;
          count_d     = count_q - CNT_ONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        if (!empty_q) begin
          // Replace-top: old top leaves, new data takes its slot.
          data_out_d  = top_data_s;
          out_valid_d = 1'b1;
          wr_en_s     = 1'b1;
          wr_idx_s    = top_idx_s;
        end else begin
          // Nothing to pop: the push still lands, the pop is an error.
          wr_en_s     = 1'b1;
          wr_idx_s    = {AW{1'b0}};
          count_d     = CNT_ONE;
          underflow_d = 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == {CW{1'b0}});
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RstN) begin
      count_q     <= {CW{1'b0}};
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      data_out_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset but reset blocks any write.
  always_ff @(posedge clk) begin
    if (RstN && wr_en_s) begin
      mem_q[wr_idx_s] <= bus.Data_In;
    end
  end

`ifdef STACK_HWM_EN
  logic [CW-1:0] max_count_q, max_count_d;

  // High-water mark follows the post-edge occupancy.
  always_comb begin
    if (count_d > max_count_q) begin
      max_count_d = count_d;
    end else begin
      max_count_d = max_count_q;
    end
  end

  // High-water mark register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!RstN) begin
      max_count_q <= {CW{1'b0}};
    end else begin
      max_count_q <= max_count_d;
    end
  end

  assign bus.Max_Count = max_count_q;
`else
  assign bus.Max_Count = {CW{1'b0}};
`endif

  assign bus.Data_Out  = data_out_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Count     = count_q;
  assign bus.Full      = full_q;
  assign bus.Empty     = empty_q;
  assign bus.Overflow  = overflow_q;
  assign bus.Underflow = underflow_q;
  assign bus.Top       = empty_q ? {WIDTH{1'b0}} : top_data_s;

endmodule
